// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// cordic_pkg : shared constants and helpers for the atan2 CORDIC pipeline
// Rev 1.0    : initial release
// ============================================================================
package cordic_pkg;

    // Fractional guard bits carried below the input LSB through the rotations.
    localparam int  GUARD    = 6;
    localparam real PI       = 3.14159265358979323846;
    localparam real GAIN_INV = 0.6072529;

    // Elementary angle atan(2^-k) as a fraction of the full circle (2^nba),
    // rounded to nearest; evaluated only at elaboration.
    function automatic longint atan_k(input int k, input int nba);
        return longint'($atan(2.0 ** (-k)) * (2.0 ** nba) / (2.0 * PI));
    endfunction

    // Inverse CORDIC gain scaled to 2^nbi, rounded to nearest.
    function automatic longint gain_k(input int nbi);
        return longint'(GAIN_INV * (2.0 ** nbi));
    endfunction

endpackage
`default_nettype wire

// File: rtl/atan2_cordic_if.sv
`default_nettype none
// ============================================================================
// atan2_cordic_if : sample/phase bus of atan2_cordic (mag with ATAN2_MAG_EN)
// Rev 1.0         : initial release
// ============================================================================
interface atan2_cordic_if #(
    parameter int NBI = 18,
    parameter int NBA = 22
);
    logic                  iv;
    logic signed [NBI-1:0] i;
    logic signed [NBI-1:0] q;
    logic                  ov;
    logic [NBA-1:0]        phase;
`ifdef ATAN2_MAG_EN
    logic [NBI:0]          mag;

    modport master (output iv, i, q, input  ov, phase, mag);
    modport slave  (input  iv, i, q, output ov, phase, mag);
`else
    modport master (output iv, i, q, input  ov, phase);
    modport slave  (input  iv, i, q, output ov, phase);
`endif
endinterface
`default_nettype wire

// File: rtl/cordic_vec_stage.sv
`default_nettype none
// ============================================================================
// cordic_vec_stage : one vectoring-mode micro-rotation with valid/zero flags
// Rev 1.0          : initial release
// ============================================================================
module cordic_vec_stage
    import cordic_pkg::*;
#(
    parameter int STAGE = 0,
    parameter int W     = 26,
    parameter int NBA   = 22
) (
    input  wire logic                 c,
    input  wire logic                 rst_n,
    input  wire logic                 src_vld,
    input  wire logic                 src_zero,
    input  wire logic signed [W-1:0]  src_x,
    input  wire logic signed [W-1:0]  src_y,
    input  wire logic [NBA-1:0]       src_z,
    output logic                      dst_vld,
    output logic                      dst_zero,
    output logic signed [W-1:0]       dst_x,
    output logic signed [W-1:0]       dst_y,
    output logic [NBA-1:0]            dst_z
);

    localparam logic [NBA-1:0] ANGLE = NBA'(atan_k(STAGE, NBA));

    logic signed [W-1:0] shift_x;
    logic signed [W-1:0] shift_y;

    assign shift_x = src_x >>> STAGE;
    assign shift_y = src_y >>> STAGE;

    // Rotate toward y = 0; z accumulates the angle removed and wraps freely.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            dst_vld  <= 1'b0;
            dst_zero <= 1'b0;
            dst_x    <= '0;
            dst_y    <= '0;
            dst_z    <= '0;
        end else begin
            dst_vld  <= src_vld;
            dst_zero <= src_zero;
            if (!src_y[W-1]) begin
                dst_x <= src_x + shift_y;
                dst_y <= src_y - shift_x;
                dst_z <= src_z + ANGLE;
            end else begin
                dst_x <= src_x - shift_y;
                dst_y <= src_y + shift_x;
                dst_z <= src_z - ANGLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/atan2_cordic.sv
`default_nettype none
// ============================================================================
// atan2_cordic : pipelined vectoring CORDIC, signed I/Q -> full-circle phase
// Rev 1.0      : initial release; `ATAN2_MAG_EN adds the magnitude output stage
// ============================================================================
module atan2_cordic
    import cordic_pkg::*;
#(
    parameter int NBI = 18,
    parameter int NBA = 22,
    parameter int NIT = 20
) (
    input  wire logic     c,
    input  wire logic     rst_n,
    atan2_cordic_if.slave bus
);

    localparam int             W    = NBI + 2 + GUARD;
    localparam logic [NBA-1:0] HALF = {1'b1, {(NBA-1){1'b0}}};

    logic                neg;
    logic                is_zero;
    logic signed [W-1:0] wide_i;
    logic signed [W-1:0] wide_q;

    // Two integer headroom bits cover -(-2^(NBI-1)) and the CORDIC gain.
    assign wide_i  = $signed({{2{bus.i[NBI-1]}}, bus.i, {GUARD{1'b0}}});
    assign wide_q  = $signed({{2{bus.q[NBI-1]}}, bus.q, {GUARD{1'b0}}});
    assign neg     = bus.i[NBI-1];
    assign is_zero = (bus.i == '0) && (bus.q == '0);

    logic                pre_vld;
    logic                pre_zero;
    logic signed [W-1:0] pre_x;
    logic signed [W-1:0] pre_y;
    logic [NBA-1:0]      pre_z;

    // Left half-plane is folded by 180 degrees so the rotations always converge.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            pre_vld  <= 1'b0;
            pre_zero <= 1'b0;
            pre_x    <= '0;
            pre_y    <= '0;
            pre_z    <= '0;
        end else begin
            pre_vld  <= bus.iv;
            pre_zero <= is_zero;
            pre_x    <= neg ? -wide_i : wide_i;
            pre_y    <= neg ? -wide_q : wide_q;
            pre_z    <= neg ? HALF : '0;
        end
    end

    logic                vld  [NIT+1];
    logic                zero [NIT+1];
    logic signed [W-1:0] xs   [NIT+1];
    logic signed [W-1:0] ys   [NIT+1];
    logic [NBA-1:0]      zs   [NIT+1];

    assign vld[0]  = pre_vld;
    assign zero[0] = pre_zero;
    assign xs[0]   = pre_x;
    assign ys[0]   = pre_y;
    assign zs[0]   = pre_z;

    for (genvar k = 0; k < NIT; k++) begin : g_stage
        cordic_vec_stage #(
            .STAGE (k),
            .W     (W),
            .NBA   (NBA)
        ) u_stage (
            .c        (c),
            .rst_n    (rst_n),
            .src_vld  (vld[k]),
            .src_zero (zero[k]),
            .src_x    (xs[k]),
            .src_y    (ys[k]),
            .src_z    (zs[k]),
            .dst_vld  (vld[k+1]),
            .dst_zero (zero[k+1]),
            .dst_x    (xs[k+1]),
            .dst_y    (ys[k+1]),
            .dst_z    (zs[k+1])
        );
    end

`ifdef ATAN2_MAG_EN
    localparam logic [NBI-1:0] KGAIN = NBI'(gain_k(NBI));

    logic               out_vld;
    logic [NBA-1:0]     out_phase;
    logic [W-1:0]       out_x;
    logic [W+NBI-1:0]   prod;

    assign prod = out_x * KGAIN;

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            out_vld   <= 1'b0;
            out_phase <= '0;
            out_x     <= '0;
            bus.ov    <= 1'b0;
            bus.phase <= '0;
            bus.mag   <= '0;
        end else begin
            out_vld   <= vld[NIT];
            out_phase <= zero[NIT] ? '0 : zs[NIT];
            out_x     <= zero[NIT] ? '0 : xs[NIT];
            bus.ov    <= out_vld;
            bus.phase <= out_phase;
            // Drop both the gain-constant scaling and the guard bits.
            bus.mag   <= (NBI+1)'(prod >> (NBI + GUARD));
        end
    end
`else
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            bus.ov    <= 1'b0;
            bus.phase <= '0;
        end else begin
            bus.ov    <= vld[NIT];
            bus.phase <= zero[NIT] ? '0 : zs[NIT];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_atan2_cordic.sv
`default_nettype none
// ============================================================================
// tb_atan2_cordic : directed vectors and I/Q sweeps against an atan2 model
// Rev 1.0         : initial release; honours ATAN2_MAG_EN
// ============================================================================
module tb_atan2_cordic;

    localparam int  NBI    = 18;
    localparam int  NBA    = 22;
    localparam int  NIT    = 20;
`ifdef ATAN2_MAG_EN
    localparam int  L      = NIT + 3;
`else
    localparam int  L      = NIT + 2;
`endif
    localparam int  TOL    = 16;
    localparam int  MTOL   = 4;
    localparam real TWO_PI = 6.283185307179586;
    localparam real AMP    = 131071.0;

    logic c     = 1'b0;
    logic rst_n = 1'b0;

    always #5 c = ~c;

    atan2_cordic_if #(.NBI(NBI), .NBA(NBA)) bus ();

    atan2_cordic #(.NBI(NBI), .NBA(NBA), .NIT(NIT)) dut (
        .c     (c),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic int ref_phase(input int ii, input int qq);
        real    a;
        longint p;
        if (ii == 0 && qq == 0) return 0;
        a = $atan2(real'(qq), real'(ii));
        if (a < 0.0) a = a + TWO_PI;
        p = longint'(a * real'(1 << NBA) / TWO_PI);
        return int'(p % (longint'(1) << NBA));
    endfunction

    function automatic int ref_mag(input int ii, input int qq);
        return int'($sqrt(real'(ii) * real'(ii) + real'(qq) * real'(qq)));
    endfunction

    function automatic int phase_err(input int a, input int b);
        logic signed [NBA-1:0] d;
        d = NBA'(a - b);
        return (d < 0) ? -int'(d) : int'(d);
    endfunction

    typedef struct {
        bit v;
        bit zero;
        int ph;
        int mg;
    } exp_t;

    exp_t pipe [L];

    // Expected output stream: each sampled input reappears L-1 edges later.
    always @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < L; k++) pipe[k] <= '{v: 1'b0, zero: 1'b0, ph: 0, mg: 0};
        end else begin
            for (int k = L - 1; k > 0; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= '{v:    bus.iv,
                         zero: (bus.i == 0) && (bus.q == 0),
                         ph:   ref_phase(int'(bus.i), int'(bus.q)),
                         mg:   ref_mag(int'(bus.i), int'(bus.q))};
        end
    end

    initial begin
        forever begin
            @(negedge c);
            if (rst_n) begin
                check("ov_stream", bus.ov == pipe[L-1].v, bus.ov, pipe[L-1].v);
                if (pipe[L-1].v && bus.ov) begin
                    if (pipe[L-1].zero)
                        check("phase_zero_stream", bus.phase == 0, bus.phase, 0);
                    else
                        check("phase_stream", phase_err(int'(bus.phase), pipe[L-1].ph) <= TOL,
                              bus.phase, pipe[L-1].ph);
`ifdef ATAN2_MAG_EN
                    if (pipe[L-1].zero)
                        check("mag_zero_stream", bus.mag == 0, bus.mag, 0);
                    else
                        check("mag_stream", int'(bus.mag) >= pipe[L-1].mg - MTOL &&
                              int'(bus.mag) <= pipe[L-1].mg + MTOL, bus.mag, pipe[L-1].mg);
`endif
                end
            end
        end
    end

    task automatic drive(input bit v, input int ii, input int qq);
        @(posedge c);
        #1;
        bus.iv = v;
        bus.i  = NBI'(ii);
        bus.q  = NBI'(qq);
    endtask

    // Single sample; measures latency and checks against a literal phase/mag.
    task automatic shot(input string name, input int ii, input int qq,
                        input int exp_ph, input int exp_mg);
        int n;
        int tol;
        drive(1'b1, ii, qq);
        n = 0;
        while (n < 4 * L) begin
            @(posedge c);
            #1;
            bus.iv = 1'b0;
            n++;
            if (bus.ov) break;
        end
        tol = (ii == 0 && qq == 0) ? 0 : TOL;
        check({name, "_latency"}, n == L, n, L);
        check({name, "_phase"}, phase_err(int'(bus.phase), exp_ph) <= tol, bus.phase, exp_ph);
`ifdef ATAN2_MAG_EN
        tol = (ii == 0 && qq == 0) ? 0 : MTOL;
        check({name, "_mag"}, int'(bus.mag) >= exp_mg - tol && int'(bus.mag) <= exp_mg + tol,
              bus.mag, exp_mg);
`endif
    endtask

    function automatic int sweep_i(input int a);
        return int'(AMP * $cos(real'(a) * TWO_PI / 4096.0));
    endfunction

    function automatic int sweep_q(input int a);
        return int'(AMP * $sin(real'(a) * TWO_PI / 4096.0));
    endfunction

    initial begin
        bus.iv = 1'b0;
        bus.i  = '0;
        bus.q  = '0;

        repeat (3) @(posedge c);
        @(negedge c);
        check("reset_ov", bus.ov == 1'b0, bus.ov, 0);
        check("reset_phase", bus.phase == 0, bus.phase, 0);
`ifdef ATAN2_MAG_EN
        check("reset_mag", bus.mag == 0, bus.mag, 0);
`endif
        @(posedge c);
        #2 rst_n = 1'b1;

        check("model_pos_i", ref_phase(100000, 0) == 0, ref_phase(100000, 0), 0);
        check("model_pos_q", ref_phase(0, 100000) == 'h100000, ref_phase(0, 100000), 'h100000);
        check("model_neg_i", ref_phase(-100000, 0) == 'h200000, ref_phase(-100000, 0), 'h200000);
        check("model_neg_q", ref_phase(0, -100000) == 'h300000, ref_phase(0, -100000), 'h300000);
        check("model_extreme", ref_phase(-131072, -1) == 'h200005, ref_phase(-131072, -1), 'h200005);
        check("model_diag", ref_phase(92681, 92681) == 'h080000, ref_phase(92681, 92681), 'h080000);
        check("model_mag", ref_mag(92681, 92681) == 131071, ref_mag(92681, 92681), 131071);

        shot("pos_i",    100000,       0, 'h000000, 100000);
        shot("pos_q",         0,  100000, 'h100000, 100000);
        shot("neg_i",   -100000,       0, 'h200000, 100000);
        shot("neg_q",         0, -100000, 'h300000, 100000);
        shot("extreme", -131072,      -1, 'h200005, 131072);
        shot("zero",          0,       0, 'h000000, 0);
        shot("diag",      92681,   92681, 'h080000, 131071);

        for (int a = 0; a < 4096; a++) drive(1'b1, sweep_i(a), sweep_q(a));
        for (int a = 0; a < 4096; a++) drive($urandom_range(0, 3) != 0, sweep_i(a), sweep_q(a));

        // Reset in the middle of a full burst: everything in flight is dropped.
        for (int a = 0; a < 40; a++) drive(1'b1, sweep_i(a * 97), sweep_q(a * 97));
        #1;
        rst_n  = 1'b0;
        bus.iv = 1'b0;
        #1;
        check("midreset_ov", bus.ov == 1'b0, bus.ov, 0);
        check("midreset_phase", bus.phase == 0, bus.phase, 0);
        @(posedge c);
        #2 rst_n = 1'b1;
        repeat (L + 4) drive(1'b0, 0, 0);
        shot("after_reset", 0, 100000, 'h100000, 100000);

        repeat (L + 4) drive(1'b0, 0, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
